// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input with a one-entry holding register,
// framed as start bit, data LSB first, optional parity bit, then one or two stop bits.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 32'd16,
  parameter int unsigned DATA_BITS    = 32'd8,
  parameter int unsigned PARITY       = 32'd0,
  parameter int unsigned STOP_BITS    = 32'd1
) (
  input  logic                 tx_Clk,
  input  logic                 tx_Rst,
  input  logic [DATA_BITS-1:0] i_TX_data,
  input  logic                 i_TX_valid,
  output logic                 o_TX_ready,
  output logic                 o_TX_serial,
  output logic                 o_TX_active,
  output logic                 o_TX_done
);

  localparam int CW = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 32'd1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 32'd1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 32'd1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 32'd1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(32'd1);
  localparam bit            HAS_PARITY = (PARITY != 32'd0);
  localparam bit            ODD_PARITY = (PARITY == 32'd2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    logic even_bit;
    even_bit = ^word;
    return ODD_PARITY ? ~even_bit : even_bit;
  endfunction

  state_t                 state_r, state_next_s;
  logic [CW-1:0]          cnt_r, cnt_next_s;
  logic [IW-1:0]          idx_r, idx_next_s;
  logic [DATA_BITS-1:0]   shift_r, shift_next_s;
  logic                   par_r, par_next_s;
  logic [DATA_BITS-1:0]   hold_r, hold_next_s;
  logic                   hold_full_r, hold_full_next_s;
  logic                   serial_next_s;
  logic                   active_next_s;
  logic                   done_next_s;
  logic                   accept_s;
  logic                   direct_s;
  logic                   hold_wr_s;
  logic                   bit_tick_s;

  assign accept_s   = i_TX_valid & o_TX_ready;
  assign direct_s   = accept_s & (state_r == ST_IDLE) & ~hold_full_r;
  assign hold_wr_s  = accept_s & ~direct_s;
  assign bit_tick_s = (cnt_r == CNT_LAST);

  // Next-state, datapath and output decode for the frame sequencer
  always_comb begin
    state_next_s     = state_r;
    idx_next_s       = idx_r;
    shift_next_s     = shift_r;
    par_next_s       = par_r;
    hold_next_s      = hold_r;
    hold_full_next_s = hold_full_r;
    done_next_s      = 1'b0;
    serial_next_s    = 1'b1;

    if ((state_r == ST_IDLE) || bit_tick_s) begin
      cnt_next_s = {CW{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        idx_next_s = {IW{1'b0}};
        if (hold_full_r) begin
          shift_next_s     = hold_r;
          par_next_s       = parity_of(hold_r);
          hold_full_next_s = 1'b0;
          state_next_s     = ST_START;
        end else if (direct_s) begin
          shift_next_s = i_TX_data;
          par_next_s   = parity_of(i_TX_data);
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_tick_s) begin
          idx_next_s   = {IW{1'b0}};
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          if (idx_r == IDX_LAST) begin
            idx_next_s   = {IW{1'b0}};
            state_next_s = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            idx_next_s   = idx_r + IDX_ONE;
            shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_tick_s) begin
          idx_next_s   = {IW{1'b0}};
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_tick_s) begin
          if (idx_r == STOP_LAST) begin
            idx_next_s  = {IW{1'b0}};
            done_next_s = 1'b1;
            // A queued word starts on the very next bit-time, no idle gap.
            if (hold_full_r) begin
              shift_next_s     = hold_r;
              par_next_s       = parity_of(hold_r);
              hold_full_next_s = 1'b0;
              state_next_s     = ST_START;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            idx_next_s = idx_r + IDX_ONE;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        idx_next_s   = {IW{1'b0}};
      end
    endcase

    if (hold_wr_s) begin
      hold_next_s      = i_TX_data;
      hold_full_next_s = 1'b1;
    end else begin
      hold_next_s = hold_next_s;
    end

    case (state_next_s)
      ST_IDLE:   serial_next_s = 1'b1;
      ST_START:  serial_next_s = 1'b0;
      ST_DATA:   serial_next_s = shift_next_s[0];
      ST_PARITY: serial_next_s = par_next_s;
      ST_STOP:   serial_next_s = 1'b1;
      default:   serial_next_s = 1'b1;
    endcase

    if (state_next_s != ST_IDLE) begin
      active_next_s = 1'b1;
    end else begin
      active_next_s = 1'b0;
    end
  end

  // State, counters, datapath and registered outputs
  always_ff @(posedge tx_Clk) begin
    if (tx_Rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      idx_r       <= {IW{1'b0}};
      shift_r     <= {DATA_BITS{1'b0}};
      par_r       <= 1'b0;
      hold_r      <= {DATA_BITS{1'b0}};
      hold_full_r <= 1'b0;
      o_TX_serial <= 1'b1;
      o_TX_active <= 1'b0;
      o_TX_done   <= 1'b0;
      o_TX_ready  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      idx_r       <= idx_next_s;
      shift_r     <= shift_next_s;
      par_r       <= par_next_s;
      hold_r      <= hold_next_s;
      hold_full_r <= hold_full_next_s;
      o_TX_serial <= serial_next_s;
      o_TX_active <= active_next_s;
      o_TX_done   <= done_next_s;
      o_TX_ready  <= ~hold_full_next_s;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that produces the serial stream consumed by the UART receiver on the same link.
- Accepts parallel data words through a valid/ready handshake and serialises each one as start bit, data bits LSB first, optional parity bit, and one or two stop bits.
- Has a one-entry holding register so an upstream producer can queue the next word during transmission; queued frames go out back-to-back with no idle gap.

Parameters:
CLKS_PER_BIT, 16, tx_Clk cycles per serial bit; legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
tx_Clk  input  1  clock; all logic on rising edge
tx_Rst  input  1  synchronous reset, active-high
i_TX_data  input  DATA_BITS  word to send; sampled only on an accept edge
i_TX_valid  input  1  producer has a word on i_TX_data
o_TX_ready  output  1  block can accept a word this cycle
o_TX_serial  output  1  serial line; idle level high
o_TX_active  output  1  a frame is on the line (START_BIT..STOP_BIT)
o_TX_done  output  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
- One clock (tx_Clk). Reset is synchronous and active-high (tx_Rst). All outputs are registered.
- Reset values: o_TX_serial=1, o_TX_active=0, o_TX_done=0, o_TX_ready=0.
  - o_TX_ready rises on the first edge after tx_Rst deasserts.
  - The holding register is cleared by reset.
- Reset mid-frame: the frame is aborted immediately. The line returns high on the edge where reset is sampled. The queued word is discarded. No o_TX_done pulse.
- Accept: an edge where i_TX_valid=1 and o_TX_ready=1.
- o_TX_ready = NOT hold_full (registered). A producer holding valid while ready=0 is stalled. Its data must stay stable, and it is not captured.
- Routing of an accepted word:
  - FSM in IDLE and holding register empty: the word loads straight into the shifter. State goes to START_BIT. o_TX_serial goes low and o_TX_active goes high, both after the same edge.
  - Otherwise: the word goes into the holding register and hold_full is set.
- Parity is computed at shifter-load time over DATA_BITS.
  - Even: parity bit = XOR of the data.
  - Odd: parity bit = NOT XOR of the data.
- FSM states:
  - IDLE: serial=1, active=0. If hold_full, load the shifter from the holding register, clear hold_full, and go to START_BIT.
  - START_BIT: serial=0 for CLKS_PER_BIT cycles, then DATA_BITS.
  - DATA_BITS: serial = shifter[0]. Shift right every CLKS_PER_BIT cycles. After DATA_BITS bits, go to PARITY_BIT if PARITY!=0, else STOP_BIT.
  - PARITY_BIT: serial = parity bit for CLKS_PER_BIT cycles, then STOP_BIT.
  - STOP_BIT: serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of STOP_BIT, on its last cycle's edge:
  - o_TX_done=1 for exactly one cycle.
  - If hold_full (including a word accepted on that same edge? no, ready was 0 if full): load the shifter, clear hold_full, go to START_BIT. o_TX_active stays 1 and serial drops low on the next bit-time with zero gap.
  - Otherwise go to IDLE.
- Simultaneous accept and hold drain: hold_full clears on the drain edge, so ready returns 1 on the following cycle. An accept is never lost or duplicated.
- Counters:
  - Bit-time counter is sized ceil(log2(CLKS_PER_BIT)) bits, counts 0..CLKS_PER_BIT-1, and wraps to 0 at every bit boundary.
  - Bit index counter is sized for DATA_BITS.
  - No counter wraps mid-bit.
- Frame length in cycles = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS).
- i_TX_data is ignored outside accept edges. An X on i_TX_data when no accept occurs must not propagate.

Test Plan:
- Defaults, send 0xA5 into an idle block:
  - serial low exactly 1 edge after accept;
  - bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles (160 cycles total);
  - o_TX_done high for 1 cycle at cycle 160;
  - o_TX_active high for 160 cycles.
- Back-to-back 0x3C then 0xC3 with valid held:
  - second word is accepted into hold during frame 1, and ready=0 until the drain edge;
  - frame 2's start bit begins immediately after frame 1's stop bit (no high gap beyond the stop bit);
  - two done pulses, 160 cycles apart.
- PARITY=1, send 0x07: parity bit = 1. PARITY=2, send 0x07: parity bit = 0. In both cases the frame is 176 cycles.
- Backpressure: hold full plus a third word with valid=1:
  - ready=0 and the third word is not captured until the first frame finishes;
  - then it is transmitted third, with the correct value.
- Assert tx_Rst at cycle 50 of a frame with a queued word:
  - serial=1, active=0, ready=0 after that edge;
  - no done pulse;
  - queued word never transmitted;
  - ready=1 one edge after reset release.
- STOP_BITS=2, DATA_BITS=5, CLKS_PER_BIT=4, send 0x1F: frame = 0,1,1,1,1,1,1,1, 32 cycles, done pulse at cycle 32.
